// File: rtl/board_writer_if.sv
// Board-writer bus: move/commit requests and preset loads in, registered board and status out.
interface board_writer_if #(
  parameter int DATA_W = 32
);
  logic                         commit;
  logic [3:0][3:0][DATA_W-1:0]  matriz_modificada;
  logic                         load_en;
  logic [3:0][3:0][DATA_W-1:0]  load_board;
  logic [3:0][3:0][DATA_W-1:0]  matriz_resultante;
  logic                         busy;
  logic                         done;
  logic                         moved;
  logic [3:0]                   spawn_idx;

  modport master (
    output commit, matriz_modificada, load_en, load_board,
    input  matriz_resultante, busy, done, moved, spawn_idx
  );

  modport slave (
    input  commit, matriz_modificada, load_en, load_board,
    output matriz_resultante, busy, done, moved, spawn_idx
  );
endinterface

// File: rtl/board_writer.sv
// Owns the 4x4 game board: commits post-move boards, spawns a 2/4 tile in a
// pseudo-random empty cell, and seeds a fresh game with two tiles after reset.
module board_writer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [3:0]  FOUR_CODE = 4'd0,
  parameter int          DATA_W    = 32
) (
  input logic           clk,
  input logic           rst,
  board_writer_if.slave bus
);
  typedef logic [3:0][3:0][DATA_W-1:0] board_t;
  typedef enum logic [2:0] {INIT1, INIT2, IDLE, CMP, SEARCH, WRITE, FIN} state_t;

  state_t      state, state_nx, ret;
  board_t      board;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [3:0]  idx, probe, spawn_idx;
  logic        chg, busy, done, moved;
  logic        cell_empty, board_diff, spawn_four;

  function automatic logic [DATA_W-1:0] cell_at(input board_t m, input logic [3:0] i);
    return m[i[3:2]][i[1:0]];
  endfunction

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cell_empty = (cell_at(board, idx) == '0);
  assign board_diff = (bus.matriz_modificada != board);
  assign spawn_four = (lfsr[7:4] == FOUR_CODE);

  assign bus.matriz_resultante = board;
  assign bus.busy              = busy;
  assign bus.done              = done;
  assign bus.moved             = moved;
  assign bus.spawn_idx         = spawn_idx;

  always_comb begin
    state_nx = state;
    case (state)
      INIT1, INIT2: state_nx = SEARCH;
      // load_en has priority: a simultaneous commit is dropped
      IDLE:   if (!bus.load_en && bus.commit) state_nx = CMP;
      CMP:    state_nx = board_diff ? SEARCH : FIN;
      SEARCH: begin
        if (cell_empty)          state_nx = WRITE;
        else if (probe == 4'd15) state_nx = FIN;
      end
      WRITE:  state_nx = ret;
      FIN:    state_nx = IDLE;
      default: state_nx = INIT1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= INIT1;
      ret       <= INIT2;
      board     <= '0;
      lfsr      <= LFSR_SEED;
      busy      <= 1'b0;
      done      <= 1'b0;
      moved     <= 1'b0;
      spawn_idx <= '0;
      idx       <= '0;
      probe     <= '0;
      chg       <= 1'b0;
    end else begin
      state <= state_nx;
      lfsr  <= {lfsr[14:0], lfsr_fb};
      busy  <= (state_nx != IDLE) && (state_nx != FIN);
      done  <= (state_nx == FIN) || (state == IDLE && bus.load_en);
      // moved changes only together with the done pulse
      if (state_nx == FIN) moved <= (state == CMP) ? 1'b0 : chg;
      case (state)
        INIT1: begin
          idx   <= lfsr[3:0];
          probe <= '0;
          ret   <= INIT2;
        end
        INIT2: begin
          idx   <= lfsr[3:0];
          probe <= '0;
          ret   <= FIN;
        end
        IDLE: begin
          if (bus.load_en) begin
            board <= bus.load_board;
            moved <= 1'b0;
          end
        end
        CMP: begin
          if (board_diff) begin
            board <= bus.matriz_modificada;
            chg   <= 1'b1;
            idx   <= lfsr[3:0];
            probe <= '0;
            ret   <= FIN;
          end
        end
        SEARCH: begin
          if (!cell_empty) begin
            idx   <= idx + 4'd1;
            probe <= probe + 4'd1;
          end
        end
        WRITE: begin
          board[idx[3:2]][idx[1:0]] <= spawn_four ? DATA_W'(4) : DATA_W'(2);
          spawn_idx                 <= idx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: init spawn, preset load, commit paths, busy behaviour, mid-run reset.
module tb_board_writer;
  typedef logic [3:0][3:0][31:0] board_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  board_writer_if #(.DATA_W(32)) bus ();

  board_writer #(
    .LFSR_SEED(16'hACE1),
    .FOUR_CODE(4'd0),
    .DATA_W   (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  board_t init_board;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_nz(input board_t b);
    int cnt = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] != 0) cnt++;
    return cnt;
  endfunction

  function automatic bit legal_tiles(input board_t b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] != 0 && b[r][c] != 2 && b[r][c] != 4) return 1'b0;
    return 1'b1;
  endfunction

  // Waits for done; n = edges after the request edge (1 = first edge), -1 on timeout.
  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (i == 1) begin
        bus.commit  = 1'b0;
        bus.load_en = 1'b0;
      end
      if (bus.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic preset(input board_t b);
    bus.load_board = b;
    bus.load_en    = 1'b1;
    tick();
    bus.load_en    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (bus.matriz_resultante !== '0) begin
      n_fail++; $display("FAIL reset_board: got %h want 0", bus.matriz_resultante);
    end
    n_checks++;
    if ({bus.busy, bus.done, bus.moved} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got busy/done/moved=%b want 000", {bus.busy, bus.done, bus.moved});
    end
    n_checks++;
    if (bus.spawn_idx !== 4'd0) begin
      n_fail++; $display("FAIL reset_spawn_idx: got %0d want 0", bus.spawn_idx);
    end
    rst = 1'b1;
    wait_done(35, n);
    n_checks++;
    if (n < 0) begin
      n_fail++; $display("FAIL init_timeout: got no done want done within 35 cycles");
    end
    n_checks++;
    if (count_nz(bus.matriz_resultante) != 2) begin
      n_fail++; $display("FAIL init_tile_count: got %0d want 2", count_nz(bus.matriz_resultante));
    end
    n_checks++;
    if (!legal_tiles(bus.matriz_resultante)) begin
      n_fail++; $display("FAIL init_tile_values: got %h want only 0/2/4", bus.matriz_resultante);
    end
    // First search starts at LFSR_SEED[3:0] = 1 on an empty board.
    n_checks++;
    if (bus.matriz_resultante[0][1] == 0) begin
      n_fail++; $display("FAIL init_first_cell: got cell1=%0d want non-zero", bus.matriz_resultante[0][1]);
    end
    n_checks++;
    if ({bus.busy, bus.moved} !== 2'b00) begin
      n_fail++; $display("FAIL init_done_flags: got busy/moved=%b want 00", {bus.busy, bus.moved});
    end
    init_board = bus.matriz_resultante;
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL init_done_pulse: got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_determinism();
    int n;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wait_done(35, n);
    n_checks++;
    if (n < 0 || bus.matriz_resultante !== init_board) begin
      n_fail++; $display("FAIL determinism: got %h want %h (n=%0d)", bus.matriz_resultante, init_board, n);
    end
    tick();
  endtask

  task automatic test_load();
    board_t lb = '0;
    lb[0][0] = 2;
    bus.load_board = lb;
    bus.load_en    = 1'b1;
    tick();
    bus.load_en    = 1'b0;
    n_checks++;
    if (bus.matriz_resultante !== lb) begin
      n_fail++; $display("FAIL load_board: got %h want %h", bus.matriz_resultante, lb);
    end
    n_checks++;
    if ({bus.done, bus.moved, bus.busy} !== 3'b100) begin
      n_fail++; $display("FAIL load_flags: got done/moved/busy=%b want 100", {bus.done, bus.moved, bus.busy});
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.matriz_resultante !== lb) begin
      n_fail++; $display("FAIL load_no_spawn: got done=%b board=%h want done=0 board=%h", bus.done, bus.matriz_resultante, lb);
    end
  endtask

  task automatic test_commit_same();
    int     n;
    board_t lb = '0;
    lb[0][0] = 2;
    bus.matriz_modificada = lb;
    bus.commit = 1'b1;
    wait_done(25, n);
    n_checks++;
    if (n != 2) begin
      n_fail++; $display("FAIL same_latency: got %0d want 2", n);
    end
    n_checks++;
    if (bus.moved !== 1'b0 || bus.matriz_resultante !== lb) begin
      n_fail++; $display("FAIL same_result: got moved=%b board=%h want moved=0 board=%h", bus.moved, bus.matriz_resultante, lb);
    end
    tick();
  endtask

  task automatic test_wrap();
    int     n;
    board_t pb, mm, rb;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pb[r][c] = 2;
    pb[3][3] = 0;
    preset(pb);
    mm = pb;
    mm[0][0] = 4;
    bus.matriz_modificada = mm;
    bus.commit = 1'b1;
    wait_done(25, n);
    n_checks++;
    if (n < 4 || n > 19) begin
      n_fail++; $display("FAIL wrap_latency: got %0d want 4..19", n);
    end
    n_checks++;
    if (bus.moved !== 1'b1 || bus.spawn_idx !== 4'd15) begin
      n_fail++; $display("FAIL wrap_spawn: got moved=%b spawn_idx=%0d want moved=1 spawn_idx=15", bus.moved, bus.spawn_idx);
    end
    n_checks++;
    if (bus.matriz_resultante[3][3] != 2 && bus.matriz_resultante[3][3] != 4) begin
      n_fail++; $display("FAIL wrap_tile: got %0d want 2 or 4", bus.matriz_resultante[3][3]);
    end
    rb = bus.matriz_resultante;
    rb[3][3] = 0;
    n_checks++;
    if (rb !== mm) begin
      n_fail++; $display("FAIL wrap_rest: got %h want %h", rb, mm);
    end
    tick();
  endtask

  task automatic test_full_no_spawn();
    int     n;
    board_t mm = bus.matriz_resultante;
    mm[1][2] = 8;
    bus.matriz_modificada = mm;
    bus.commit = 1'b1;
    wait_done(25, n);
    // CMP, sixteen failed probes, then FIN
    n_checks++;
    if (n != 18) begin
      n_fail++; $display("FAIL full_latency: got %0d want 18", n);
    end
    n_checks++;
    if (bus.matriz_resultante !== mm) begin
      n_fail++; $display("FAIL full_board: got %h want %h", bus.matriz_resultante, mm);
    end
    n_checks++;
    if (bus.spawn_idx !== 4'd15 || bus.moved !== 1'b1) begin
      n_fail++; $display("FAIL full_flags: got spawn_idx=%0d moved=%b want 15, 1", bus.spawn_idx, bus.moved);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int     dones = 0;
    board_t lb = '0;
    board_t mm;
    lb[0][0] = 2;
    preset(lb);
    mm = lb;
    mm[2][2] = 8;
    bus.matriz_modificada = mm;
    bus.commit = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      bus.commit  = (i == 2);
      bus.load_en = (i == 3);
      bus.load_board = '0;
      if (bus.done) dones++;
    end
    bus.commit  = 1'b0;
    bus.load_en = 1'b0;
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL busy_done_count: got %0d want 1", dones);
    end
    n_checks++;
    if (count_nz(bus.matriz_resultante) != 3 || bus.matriz_resultante[2][2] != 8 || bus.matriz_resultante[0][0] != 2) begin
      n_fail++; $display("FAIL busy_board: got %h want mm plus one spawned tile", bus.matriz_resultante);
    end
    n_checks++;
    if (bus.moved !== 1'b1) begin
      n_fail++; $display("FAIL busy_moved: got %b want 1", bus.moved);
    end
  endtask

  task automatic test_both();
    int     dones = 0;
    board_t lb = '0;
    board_t mm = '0;
    lb[1][1] = 4;
    mm[3][0] = 16;
    bus.load_board        = lb;
    bus.matriz_modificada = mm;
    bus.load_en = 1'b1;
    bus.commit  = 1'b1;
    tick();
    bus.load_en = 1'b0;
    bus.commit  = 1'b0;
    n_checks++;
    if (bus.matriz_resultante !== lb || bus.done !== 1'b1 || bus.moved !== 1'b0) begin
      n_fail++; $display("FAIL both_load: got board=%h done=%b moved=%b want board=%h done=1 moved=0", bus.matriz_resultante, bus.done, bus.moved, lb);
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.done) dones++;
    end
    n_checks++;
    if (dones != 0 || bus.matriz_resultante !== lb) begin
      n_fail++; $display("FAIL both_commit_dropped: got dones=%0d board=%h want 0, %h", dones, bus.matriz_resultante, lb);
    end
  endtask

  task automatic test_reset_mid();
    int     n;
    board_t lb = '0;
    board_t mm;
    lb[0][0] = 2;
    preset(lb);
    mm = lb;
    mm[0][1] = 2;
    bus.matriz_modificada = mm;
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy: got %b want 1", bus.busy);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.matriz_resultante !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.spawn_idx !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset: got board=%h busy=%b done=%b spawn_idx=%0d want all 0", bus.matriz_resultante, bus.busy, bus.done, bus.spawn_idx);
    end
    rst = 1'b1;
    wait_done(35, n);
    n_checks++;
    if (n < 0 || bus.matriz_resultante !== init_board || bus.moved !== 1'b0) begin
      n_fail++; $display("FAIL mid_reinit: got board=%h moved=%b n=%0d want %h moved=0", bus.matriz_resultante, bus.moved, n, init_board);
    end
    tick();
  endtask

  initial begin
    bus.commit            = 1'b0;
    bus.load_en           = 1'b0;
    bus.matriz_modificada = '0;
    bus.load_board        = '0;
    test_reset();
    test_determinism();
    test_load();
    test_commit_same();
    test_wrap();
    test_full_no_spawn();
    test_busy_ignore();
    test_both();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
